sobel_gcd_spi_regbank: RTL and testbench
========================================

Name: sobel_gcd_spi_regbank

Overview:
- Parametrised SPI-slave register bank. It is the control and status front end for the Sobel and GCD datapaths.
- Oversamples SCK, CS and SDI in the clk_i domain. A single clock domain means no SCK-domain logic.
- Decodes write and read command frames into NUM_RW control registers, NUM_RO read-only inputs and one sticky read-to-clear status register.
- Returns read data in the following frame, tagged with a validity flag and the echoed address.

Parameters:
- ADDR_WIDTH, 7: address field width. Requires NUM_RW+NUM_RO < 2^ADDR_WIDTH.
- DATA_WIDTH, 8: data field width. FRAME = 1+ADDR_WIDTH+DATA_WIDTH (default 16).
- NUM_RW, 4: number of writable control registers, at addresses 0..NUM_RW-1.
- NUM_RO, 2: number of read-only registers, at addresses NUM_RW..NUM_RW+NUM_RO-1.
- RW_RESET, 0: reset value of every RW register.

Ports:
- clk_i  in  1  system clock. Must satisfy f_clk >= 8x f_sck.
- nreset_async_i  in  1  reset, asynchronous assert, active-low.
- spi_sck_i  in  1  SPI clock, mode 0. Asynchronous to clk_i.
- spi_sdi_i  in  1  serial data in, MSB first.
- spi_cs_i  in  1  chip select, active-low.
- spi_sdo_o  out  1  serial data out, MSB first.
- reg_rw_o  out  NUM_RW*DATA_WIDTH  flattened RW registers. Register k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_stb_o  out  NUM_RW  one-cycle pulse per register on each committed write.
- reg_ro_i  in  NUM_RO*DATA_WIDTH  flattened read-only values, with the same packing as reg_rw_o.
- event_i  in  DATA_WIDTH  event bits. Any high cycle sets the matching status bit.
- spi_busy_o  out  1  high while a frame is in progress (states SHIFT and COMMIT).
- frame_err_o  out  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:

Clock, reset and reset values:
- Single clock. Reset is asynchronous and active-low.
- Reset values: reg_rw_o = RW_RESET; reg_wr_stb_o = 0; spi_sdo_o = 0; spi_busy_o = 0; frame_err_o = 0; status = 0; rd_buf = 0.

Input sampling:
- SCK, CS and SDI each pass through a 2-flop synchronizer followed by an edge-detect register.
- Synchronizer flops reset to the idle levels: SCK = 0, CS = 1.
- SDI is sampled on the cycle a synchronized SCK rising edge is detected.

Frame format (write, bit FRAME-1 down to 0):
- Bit FRAME-1: command, 1 = write, 0 = read.
- Next ADDR_WIDTH bits: address.
- Low DATA_WIDTH bits: data. The data field is don't-care for reads.

State machine:
- IDLE: on CS falling edge go to SHIFT. On entry to SHIFT, clear the bit counter and load the tx shift register from rd_buf.
- SHIFT, SCK rising edge: shift SDI in while count < FRAME. The counter saturates at FRAME+1.
- SHIFT, SCK falling edge: shift tx left; spi_sdo_o = tx MSB.
- SHIFT, CS rising edge: if count == FRAME go to COMMIT. Otherwise go to IDLE and pulse frame_err_o. Nothing is committed on an error.
- COMMIT: lasts exactly one cycle, then returns to IDLE.

Commit actions:
- Write to address < NUM_RW: update the register and pulse reg_wr_stb_o[addr] in the same cycle the new value appears.
- Write to any other address: ignored, with no error.
- Read: set rd_buf = {1'b1, addr, value}.
  - value is the RW register, the RO input, status (address 2^ADDR_WIDTH-1), or 0 for unmapped addresses.
  - Reading status clears it. An event_i bit high in the clear cycle stays set: set wins over clear.
- Write frames set rd_buf = 0, so the next response is flagged invalid.

Timing:
- Commit latency: reg_rw_o, reg_wr_stb_o and rd_buf update 4 clk_i edges after the first synchronizer flop captures CS high.
- spi_sdo_o is 0 whenever state is IDLE.
- The first tx bit is valid 4 clk_i edges after CS low is captured. The host must provide at least 6 clk_i of CS-to-first-SCK setup.

Boundary cases:
- Status register: status |= event_i every cycle.
- Back-to-back frames: valid if CS-high time >= 5 clk_i cycles.
- Extra SCK bits (count > FRAME): data is ignored and the frame is an error at CS rise.
- Reset mid-frame: the frame is lost. If CS is low at reset release, the synchronizer reset value produces a CS fall and a partial frame, which ends in frame_err_o. Registers keep their reset values.

Test Plan:
- Write, defaults: frame 0x81A5 -> reg_rw_o[15:8] = 0xA5; reg_wr_stb_o = 4'b0010 for exactly one cycle; other registers keep RW_RESET.
- Read RW: 0x81A5, then 0x0100, then 0x0000 -> SDO returns 0x0000 (write-invalidated), then 0x81A5 (valid, addr 1, data A5).
- Read RO: reg_ro_i = 0x3C5A; frames 0x0500, 0x0000 -> second response 0x853C (addr 5 = RO index 1).
- Sticky status: pulse event_i = 0x04 for one cycle; read 0x7F00 twice, then 0x0000.
  - Responses 2 and 3 are 0xFF04 and 0xFF00.
  - Repeat with event_i high during the clear cycle -> bit survives.
- Errors: 12-bit frame, then 17-bit frame -> frame_err_o pulses once each; reg_rw_o and rd_buf unchanged. Write 0x84FF (RO address) -> no strobe, no register change.
- Reset: assert nreset_async_i after 8 bits of 0x81A5 -> all outputs return to reset values; write not applied. Release with CS low, then raise CS -> frame_err_o pulse, then normal operation.

Source files
------------

// File: rtl/sobel_gcd_spi_regbank_if.sv
// SPI pin bundle between a host (master) and the register bank (slave).
interface sobel_gcd_spi_regbank_if;
    logic spi_sck_i;
    logic spi_sdi_i;
    logic spi_cs_i;
    logic spi_sdo_o;

    modport master (output spi_sck_i, output spi_sdi_i, output spi_cs_i, input spi_sdo_o);
    modport slave  (input spi_sck_i, input spi_sdi_i, input spi_cs_i, output spi_sdo_o);
endinterface

// File: rtl/sobel_gcd_spi_regbank.sv
// SPI-slave register bank: oversampled mode-0 SPI, RW control regs, RO inputs,
// sticky read-to-clear status, and read data returned in the following frame.
module sobel_gcd_spi_regbank #(
    parameter int unsigned            ADDR_WIDTH = 7,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            NUM_RW     = 4,
    parameter int unsigned            NUM_RO     = 2,
    parameter logic [DATA_WIDTH-1:0]  RW_RESET   = '0
) (
    input  logic                         clk_i,
    input  logic                         nreset_async_i,
    sobel_gcd_spi_regbank_if.slave       spi,
    output logic [NUM_RW*DATA_WIDTH-1:0] reg_rw_o,
    output logic [NUM_RW-1:0]            reg_wr_stb_o,
    input  logic [NUM_RO*DATA_WIDTH-1:0] reg_ro_i,
    input  logic [DATA_WIDTH-1:0]        event_i,
    output logic                         spi_busy_o,
    output logic                         frame_err_o
);

    localparam int unsigned FRAME = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(FRAME + 2);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    state_t                 r_state;
    logic                   r_sck_s1, r_sck_s2, r_sck_d;
    logic                   r_cs_s1, r_cs_s2, r_cs_d;
    logic                   r_sdi_s1, r_sdi_s2;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME-1:0]       r_rx;
    logic [FRAME-1:0]       r_tx;
    logic [FRAME-1:0]       r_rd_buf;
    logic [DATA_WIDTH-1:0]  r_rw [NUM_RW];
    logic [NUM_RW-1:0]      r_stb;
    logic [DATA_WIDTH-1:0]  r_status;
    logic                   r_sdo;
    logic                   r_busy;
    logic                   r_err;

    logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic                   w_cmd;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [DATA_WIDTH-1:0]  w_rd_val;
    logic                   w_stat_clr;

    // Two-flop synchronizers plus edge-detect stage; idle levels SCK=0, CS=1.
    always_ff @(posedge clk_i or negedge nreset_async_i) begin
        if (!nreset_async_i) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_cs_s1  <= 1'b1;
            r_cs_s2  <= 1'b1;
            r_cs_d   <= 1'b1;
            r_sdi_s1 <= 1'b0;
            r_sdi_s2 <= 1'b0;
        end else begin
            r_sck_s1 <= spi.spi_sck_i;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_cs_s1  <= spi.spi_cs_i;
            r_cs_s2  <= r_cs_s1;
            r_cs_d   <= r_cs_s2;
            r_sdi_s1 <= spi.spi_sdi_i;
            r_sdi_s2 <= r_sdi_s1;
        end
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s2 & r_sck_d;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_d;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_d;

    assign w_cmd  = r_rx[FRAME-1];
    assign w_addr = r_rx[FRAME-2 -: ADDR_WIDTH];
    assign w_data = r_rx[DATA_WIDTH-1:0];

    // Read-value mux; unmapped addresses read as zero.
    always_comb begin
        w_rd_val = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (w_addr == ADDR_WIDTH'(k)) w_rd_val = r_rw[k];
        end
        for (int unsigned k = 0; k < NUM_RO; k++) begin
            if (w_addr == ADDR_WIDTH'(NUM_RW + k)) w_rd_val = reg_ro_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (w_addr == STATUS_ADDR) w_rd_val = r_status;
    end

    assign w_stat_clr = (r_state == ST_COMMIT) && !w_cmd && (w_addr == STATUS_ADDR);

    // Sticky status: a set in the clear cycle wins.
    always_ff @(posedge clk_i or negedge nreset_async_i) begin
        if (!nreset_async_i) r_status <= '0;
        else                 r_status <= (w_stat_clr ? '0 : r_status) | event_i;
    end

    always_ff @(posedge clk_i or negedge nreset_async_i) begin
        if (!nreset_async_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rx     <= '0;
            r_tx     <= '0;
            r_rd_buf <= '0;
            r_stb    <= '0;
            r_sdo    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            for (int unsigned k = 0; k < NUM_RW; k++) r_rw[k] <= RW_RESET;
        end else begin
            r_stb <= '0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sdo <= 1'b0;
                    if (w_cs_fall) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_tx    <= r_rd_buf;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_sdo <= 1'b0;
                        if (r_cnt == CNT_W'(FRAME)) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        if (w_sck_rise) begin
                            if (r_cnt < CNT_W'(FRAME))     r_rx  <= {r_rx[FRAME-2:0], r_sdi_s2};
                            if (r_cnt < CNT_W'(FRAME + 1)) r_cnt <= r_cnt + CNT_W'(1);
                        end
                        // SDO tracks the tx MSB, updated with the shift on SCK fall.
                        if (w_sck_fall) begin
                            r_tx  <= {r_tx[FRAME-2:0], 1'b0};
                            r_sdo <= r_tx[FRAME-2];
                        end else begin
                            r_sdo <= r_tx[FRAME-1];
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_sdo   <= 1'b0;
                    if (w_cmd) begin
                        r_rd_buf <= '0;
                        for (int unsigned k = 0; k < NUM_RW; k++) begin
                            if (w_addr == ADDR_WIDTH'(k)) begin
                                r_rw[k]  <= w_data;
                                r_stb[k] <= 1'b1;
                            end
                        end
                    end else begin
                        r_rd_buf <= {1'b1, w_addr, w_rd_val};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_sdo   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
        assign reg_rw_o[g*DATA_WIDTH +: DATA_WIDTH] = r_rw[g];
    end

    assign reg_wr_stb_o  = r_stb;
    assign spi.spi_sdo_o = r_sdo;
    assign spi_busy_o    = r_busy;
    assign frame_err_o   = r_err;

endmodule

// File: tb/tb_sobel_gcd_spi_regbank.sv
// Self-checking bench: directed plan items plus randomized frames against a frame-level model.
module tb_sobel_gcd_spi_regbank;

    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = 8;
    localparam int unsigned NRW = 4;
    localparam int unsigned NRO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [NRW*DW-1:0]     reg_rw;
    logic [NRW-1:0]        stb;
    logic [NRO*DW-1:0]     ro;
    logic [DW-1:0]         ev;
    logic                  busy;
    logic                  ferr;

    sobel_gcd_spi_regbank_if spi_if();

    sobel_gcd_spi_regbank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO), .RW_RESET(8'h00)
    ) dut (
        .clk_i          (clk),
        .nreset_async_i (rst_n),
        .spi            (spi_if),
        .reg_rw_o       (reg_rw),
        .reg_wr_stb_o   (stb),
        .reg_ro_i       (ro),
        .event_i        (ev),
        .spi_busy_o     (busy),
        .frame_err_o    (ferr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse counters sampled away from the active edge.
    int         stb_cnt [NRW];
    logic [7:0] stb_val [NRW];
    int         err_cnt = 0;

    initial for (int k = 0; k < NRW; k++) begin stb_cnt[k] = 0; stb_val[k] = '0; end

    always @(negedge clk) begin
        for (int k = 0; k < NRW; k++) begin
            if (stb[k]) begin
                stb_cnt[k] = stb_cnt[k] + 1;
                stb_val[k] = reg_rw[k*DW +: DW];
            end
        end
        if (ferr) err_cnt = err_cnt + 1;
    end

    // Reference model state
    logic [7:0]  m_rw [NRW];
    logic [15:0] m_rd;
    logic [7:0]  m_stat;
    logic [7:0]  m_ev_hold;
    int          m_stb [NRW];
    int          m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] pack_rw();
        return {m_rw[3], m_rw[2], m_rw[1], m_rw[0]};
    endfunction

    task automatic spi_xfer(input int nbits, input logic [31:0] mosi, output logic [31:0] miso);
        miso = '0;
        spi_if.spi_cs_i = 1'b0;
        wait_clks(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_if.spi_sdi_i = mosi[i];
            wait_clks(5);
            miso = {miso[30:0], spi_if.spi_sdo_o};
            spi_if.spi_sck_i = 1'b1;
            if (i == nbits - 4) chk("busy_mid", 64'(busy), 64'd1);
            wait_clks(5);
            spi_if.spi_sck_i = 1'b0;
        end
        wait_clks(5);
        spi_if.spi_cs_i = 1'b1;
        wait_clks(10);
    endtask

    task automatic check_regs();
        chk("reg_rw", 64'(reg_rw), 64'(pack_rw()));
        for (int k = 0; k < NRW; k++) chk($sformatf("stb_cnt%0d", k), 64'(stb_cnt[k]), 64'(m_stb[k]));
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
        chk("busy_idle", 64'(busy), 64'd0);
        chk("sdo_idle", 64'(spi_if.spi_sdo_o), 64'd0);
    endtask

    // One well-formed 16-bit frame; the response carries the previous frame's result.
    task automatic do_frame(input logic cmd, input logic [6:0] addr, input logic [7:0] data,
                            output logic [15:0] resp);
        logic [31:0] miso;
        logic [15:0] exp_resp;
        logic [7:0]  val;
        exp_resp = m_rd;
        spi_xfer(16, {16'h0, cmd, addr, data}, miso);
        resp = miso[15:0];
        chk("sdo_resp", 64'(resp), 64'(exp_resp));
        if (cmd) begin
            if (addr < NRW) begin
                m_rw[addr] = data;
                m_stb[addr]++;
                chk("stb_val", 64'(stb_val[addr]), 64'(data));
            end
            m_rd = '0;
        end else begin
            if (addr < NRW)                val = m_rw[addr];
            else if (addr < NRW + NRO)     val = ro[(int'(addr) - NRW)*DW +: DW];
            else if (addr == 7'h7F)        val = m_stat;
            else                           val = '0;
            if (addr == 7'h7F) m_stat = m_ev_hold;
            m_rd = {1'b1, addr, val};
        end
        check_regs();
    endtask

    task automatic err_frame(input int nbits, input logic [31:0] mosi);
        logic [31:0] miso;
        spi_xfer(nbits, mosi, miso);
        m_err++;
        check_regs();
    endtask

    task automatic pulse_event(input logic [7:0] bits);
        ev = bits;
        wait_clks(1);
        ev = '0;
        m_stat = m_stat | bits;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NRW; k++) m_rw[k] = '0;
        m_rd   = '0;
        m_stat = '0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [6:0]  atab [10];
        logic [6:0]  a;
        logic        c;

        atab = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd9, 7'd126, 7'd127};
        rst_n = 1'b0;
        spi_if.spi_cs_i  = 1'b1;
        spi_if.spi_sck_i = 1'b0;
        spi_if.spi_sdi_i = 1'b0;
        ro = '0;
        ev = '0;
        m_ev_hold = '0;
        m_err = 0;
        for (int k = 0; k < NRW; k++) m_stb[k] = 0;
        model_reset();
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(4);

        chk("rst_reg_rw", 64'(reg_rw), 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_sdo", 64'(spi_if.spi_sdo_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ferr", 64'(ferr), 64'd0);

        // Write with defaults, then read back through the next frame
        do_frame(1'b1, 7'd1, 8'hA5, r);
        chk("wr_defaults", 64'(reg_rw), 64'h0000_A500);
        do_frame(1'b0, 7'd1, 8'h00, r);
        chk("rd_after_wr", 64'(r), 64'h0000);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("rd_rw1", 64'(r), 64'h81A5);

        // Read-only input
        ro = 16'h3C5A;
        do_frame(1'b0, 7'd5, 8'h00, r);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("rd_ro1", 64'(r), 64'h853C);

        // Sticky status, read-to-clear
        pulse_event(8'h04);
        do_frame(1'b0, 7'h7F, 8'h00, r);
        do_frame(1'b0, 7'h7F, 8'h00, r);
        chk("stat_set", 64'(r), 64'hFF04);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("stat_clr", 64'(r), 64'hFF00);

        // Event held high across the clear cycle survives the clear
        ev = 8'h10;
        m_ev_hold = 8'h10;
        wait_clks(1);
        m_stat = m_stat | 8'h10;
        do_frame(1'b0, 7'h7F, 8'h00, r);
        ev = '0;
        m_ev_hold = '0;
        do_frame(1'b0, 7'h7F, 8'h00, r);
        chk("stat_set_wins1", 64'(r), 64'hFF10);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("stat_set_wins2", 64'(r), 64'hFF10);
        do_frame(1'b0, 7'h7F, 8'h00, r);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("stat_cleared", 64'(r), 64'hFF00);

        // Malformed frames and write to a read-only address
        do_frame(1'b0, 7'd1, 8'h00, r);
        err_frame(12, 32'h0000_08FF);
        err_frame(17, 32'h0001_03FF);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("rd_buf_kept", 64'(r), 64'h81A5);
        do_frame(1'b1, 7'd4, 8'hFF, r);
        chk("ro_wr_ignored", 64'(reg_rw), 64'h0000_A500);

        // Reset mid-frame, released with CS low
        spi_if.spi_cs_i = 1'b0;
        wait_clks(8);
        for (int i = 15; i >= 8; i--) begin
            spi_if.spi_sdi_i = r[0] ^ r[0] ^ ((16'h81A5 >> i) & 16'h1) != 0;
            wait_clks(5);
            spi_if.spi_sck_i = 1'b1;
            wait_clks(5);
            spi_if.spi_sck_i = 1'b0;
        end
        rst_n = 1'b0;
        model_reset();
        wait_clks(3);
        chk("mid_rst_reg_rw", 64'(reg_rw), 64'd0);
        chk("mid_rst_stb", 64'(stb), 64'd0);
        chk("mid_rst_sdo", 64'(spi_if.spi_sdo_o), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ferr", 64'(ferr), 64'd0);
        rst_n = 1'b1;
        wait_clks(10);
        chk("partial_busy", 64'(busy), 64'd1);
        spi_if.spi_cs_i = 1'b1;
        wait_clks(10);
        m_err++;
        check_regs();
        do_frame(1'b0, 7'd1, 8'h00, r);
        do_frame(1'b0, 7'd0, 8'h00, r);
        chk("post_rst_rd", 64'(r), 64'h8100);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            ro = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_event(8'($urandom));
            a = atab[$urandom_range(0, 9)];
            c = 1'($urandom_range(0, 1));
            do_frame(c, a, 8'($urandom), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
